axis_pkt_framer: RTL and testbench

AXIS_PKT_FRAMER -- requirements
Module: axis_pkt_framer

---
 rtl/axis_pkt_framer_pkg.sv | 9 +
 rtl/axis_skid2.sv | 37 +++
 rtl/axis_pkt_framer.sv | 89 ++++++++
 tb/tb_axis_pkt_framer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_framer_pkg.sv
// axis_pkt_framer_pkg: state encoding shared by the packet framer files.
package axis_pkt_framer_pkg;
   localparam int STATE_W = 2;
   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/axis_skid2.sv
// axis_skid2: two-entry register buffer carrying data, keep and last; head entry drives the outputs.
module axis_skid2 #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic [DATA_WIDTH-1:0]   push_data,
   input  logic [DATA_WIDTH/8-1:0] push_keep,
   input  logic                    push_last,
   input  logic                    pop,
   output logic [DATA_WIDTH-1:0]   head_data,
   output logic [DATA_WIDTH/8-1:0] head_keep,
   output logic                    head_last,
   output logic [1:0]              fifo_cnt
);
   localparam int EW = DATA_WIDTH + DATA_WIDTH/8 + 1;
   logic [EW-1:0] e0, e1, din;
   assign din = {push_data, push_keep, push_last};
   assign {head_data, head_keep, head_last} = (fifo_cnt != 2'd0) ? e0 : '0;
   // e0 is always the head; e1 only holds the second entry when two are buffered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e0       <= '0;
         e1       <= '0;
         fifo_cnt <= 2'd0;
      end else begin
         if (pop)
            e0 <= (fifo_cnt == 2'd2) ? e1 : din;
         else if (push && fifo_cnt == 2'd0)
            e0 <= din;
         if (push && (fifo_cnt == 2'd2 || (fifo_cnt == 2'd1 && !pop)))
            e1 <= din;
         fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
      end
   end
endmodule

// File: rtl/axis_pkt_framer.sv
// axis_pkt_framer: frames an AXI-Stream into packets of cfg_len beats with TLAST on the final beat.
module axis_pkt_framer
   import axis_pkt_framer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [LEN_WIDTH-1:0]    cfg_len,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   S_AXI_TDATA,
   input  logic [DATA_WIDTH/8-1:0] S_AXI_TKEEP,
   input  logic                    S_AXI_TVALID,
   output logic                    S_AXI_TREADY,
   output logic [DATA_WIDTH-1:0]   M_AXI_TDATA,
   output logic [DATA_WIDTH/8-1:0] M_AXI_TKEEP,
   output logic                    M_AXI_TVALID,
   input  logic                    M_AXI_TREADY,
   output logic                    M_AXI_TLAST,
   output logic                    busy,
   output logic                    pkt_done,
   output logic                    cfg_err,
   output logic [STATE_W-1:0]      dbg_state,
   output logic [LEN_WIDTH-1:0]    dbg_in_cnt
);
   state_t               state;
   logic [LEN_WIDTH-1:0] len_q, in_cnt;
   logic [1:0]           fifo_cnt;
   logic                 accept, last_in, pop;
   // ready depends only on registered state, never on M_AXI_TREADY
   assign S_AXI_TREADY = (state == RUN) && (in_cnt != len_q) && (fifo_cnt < 2'd2);
   assign accept       = S_AXI_TVALID && S_AXI_TREADY;
   assign last_in      = in_cnt == len_q - LEN_WIDTH'(1);
   assign M_AXI_TVALID = fifo_cnt != 2'd0;
   assign pop          = M_AXI_TVALID && M_AXI_TREADY;
   assign busy         = state != IDLE;
   assign dbg_state    = state;
   assign dbg_in_cnt   = in_cnt;

   axis_skid2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
      .clk      (clk),
      .reset    (reset),
      .push     (accept),
      .push_data(S_AXI_TDATA),
      .push_keep(S_AXI_TKEEP),
      .push_last(last_in),
      .pop      (pop),
      .head_data(M_AXI_TDATA),
      .head_keep(M_AXI_TKEEP),
      .head_last(M_AXI_TLAST),
      .fifo_cnt (fifo_cnt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         len_q    <= '0;
         in_cnt   <= '0;
         pkt_done <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         cfg_err  <= 1'b0;
         case (state)
            IDLE:
               if (start) begin
                  if (cfg_len != '0) begin
                     len_q  <= cfg_len;
                     in_cnt <= '0;
                     state  <= RUN;
                  end else
                     cfg_err <= 1'b1;
               end
            RUN:
               if (accept) begin
                  in_cnt <= in_cnt + LEN_WIDTH'(1);
                  if (last_in) state <= DRAIN;
               end
            DRAIN:
               if (pop && M_AXI_TLAST) begin
                  pkt_done <= 1'b1;
                  state    <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axis_pkt_framer.sv
// tb_axis_pkt_framer: table-driven packet vectors plus hand sequences for reset, zero and unit length.
module tb_axis_pkt_framer;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [9:0]  cfg_len = '0;
   logic [31:0] S_AXI_TDATA = '0;
   logic [3:0]  S_AXI_TKEEP = '0;
   logic        S_AXI_TVALID = 1'b0, M_AXI_TREADY = 1'b0;
   logic        S_AXI_TREADY, M_AXI_TVALID, M_AXI_TLAST, busy, pkt_done, cfg_err;
   logic [31:0] M_AXI_TDATA;
   logic [3:0]  M_AXI_TKEEP;
   logic [1:0]  dbg_state;
   logic [9:0]  dbg_in_cnt;
   int          passed = 0, total = 0;

   axis_pkt_framer #(.DATA_WIDTH(32), .LEN_WIDTH(10)) dut (
      .clk(clk), .reset(reset), .cfg_len(cfg_len), .start(start),
      .S_AXI_TDATA(S_AXI_TDATA), .S_AXI_TKEEP(S_AXI_TKEEP), .S_AXI_TVALID(S_AXI_TVALID),
      .S_AXI_TREADY(S_AXI_TREADY), .M_AXI_TDATA(M_AXI_TDATA), .M_AXI_TKEEP(M_AXI_TKEEP),
      .M_AXI_TVALID(M_AXI_TVALID), .M_AXI_TREADY(M_AXI_TREADY), .M_AXI_TLAST(M_AXI_TLAST),
      .busy(busy), .pkt_done(pkt_done), .cfg_err(cfg_err), .dbg_state(dbg_state),
      .dbg_in_cnt(dbg_in_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         len;
      logic [3:0] rmask;     // M ready pattern, bit (cycle % 4)
      logic       midchg;    // retarget cfg_len=2 and re-pulse start mid-packet
      int         exp_beats;
      int         exp_span;  // last_pop - first_pop cycle, -1 = don't care
      int         exp_drop;  // S ready seen low in RUN before len reached, -1 = don't care
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      else passed++;
   endtask

   // caller is positioned just after a rising edge
   task automatic run_pkt(input vec_t v, input logic [31:0] base);
      int acc = 0, out = 0, dones = 0, first_c = -1, last_c = -1, done_c = -1, extra = 0;
      logic stalled = 1'b0, dropped = 1'b0, acc_now;
      logic [31:0] held = '0, expd;
      cfg_len = 10'(v.len); start = 1'b1;
      S_AXI_TDATA = base; S_AXI_TKEEP = base[3:0]; S_AXI_TVALID = 1'b1;
      M_AXI_TREADY = v.rmask[0];
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (stalled) chk("hold", M_AXI_TDATA, held);
         if (M_AXI_TVALID && M_AXI_TREADY) begin
            expd = base + 32'(out);
            chk("data", M_AXI_TDATA, expd);
            chk("keep", 32'(M_AXI_TKEEP), 32'(expd[3:0]));
            chk("last", 32'(M_AXI_TLAST), 32'(out == v.exp_beats - 1));
            if (first_c < 0) first_c = c;
            last_c = c;
            out++;
         end
         if (dbg_state == 2'd1 && dbg_in_cnt != 10'(v.len) && !S_AXI_TREADY) dropped = 1'b1;
         stalled = M_AXI_TVALID && !M_AXI_TREADY;
         held = M_AXI_TDATA;
         if (pkt_done) begin dones++; done_c = c; end
         acc_now = S_AXI_TVALID && S_AXI_TREADY;
         if (dones > 0 && !busy) break;
         @(posedge clk); #1;
         start = 1'b0;
         if (acc_now) begin
            acc++;
            S_AXI_TDATA = base + 32'(acc); S_AXI_TKEEP = S_AXI_TDATA[3:0];
         end
         M_AXI_TREADY = v.rmask[(c + 1) % 4];
         if (v.midchg && c == 2) begin cfg_len = 10'd2; start = 1'b1; end
      end
      chk("beats", 32'(out), 32'(v.exp_beats));
      chk("accepted", 32'(acc), 32'(v.exp_beats));
      chk("pkt_done count", 32'(dones), 32'd1);
      chk("pkt_done timing", 32'(done_c), 32'(last_c + 1));
      chk("busy end", 32'(busy), 32'd0);
      if (v.exp_span >= 0) begin
         chk("first pop cycle", 32'(first_c), 32'd2);
         chk("span", 32'(last_c - first_c), 32'(v.exp_span));
      end
      if (v.exp_drop >= 0) chk("ready drop", 32'(dropped), 32'(v.exp_drop));
      repeat (4) begin
         @(negedge clk);
         if (M_AXI_TVALID || pkt_done || busy) extra++;
      end
      chk("idle after", 32'(extra), 32'd0);
      @(posedge clk); #1;
      S_AXI_TVALID = 1'b0; M_AXI_TREADY = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      vec_t v2;
      int   n;
      vecs[0] = '{4, 4'b1111, 1'b0, 4, 3, 0};
      vecs[1] = '{3, 4'b1001, 1'b0, 3, -1, -1};
      vecs[2] = '{6, 4'b1001, 1'b0, 6, -1, 1};
      vecs[3] = '{5, 4'b1111, 1'b1, 5, 4, 0};
      vecs[4] = '{2, 4'b1010, 1'b0, 2, -1, -1};
      vecs[5] = '{7, 4'b0001, 1'b0, 7, -1, 1};
      vecs[6] = '{1, 4'b1111, 1'b0, 1, 0, 0};
      #2;
      chk("rst tvalid", 32'(M_AXI_TVALID), 0);
      chk("rst tlast", 32'(M_AXI_TLAST), 0);
      chk("rst sready", 32'(S_AXI_TREADY), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst state", 32'(dbg_state), 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 7; i++) run_pkt(vecs[i], 32'h1000_0000 * (i + 1) + 32'h10);
      // zero length start
      cfg_len = 10'd0; start = 1'b1;
      @(negedge clk);
      chk("zero pre err", 32'(cfg_err), 0);
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("zero cfg_err", 32'(cfg_err), 1);
      chk("zero busy", 32'(busy), 0);
      chk("zero sready", 32'(S_AXI_TREADY), 0);
      @(negedge clk);
      chk("zero cfg_err pulse", 32'(cfg_err), 0);
      chk("zero state", 32'(dbg_state), 0);
      // length one state walk
      @(posedge clk); #1;
      cfg_len = 10'd1; start = 1'b1; S_AXI_TVALID = 1'b1; S_AXI_TDATA = 32'hCAFE_0001;
      S_AXI_TKEEP = 4'h1; M_AXI_TREADY = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("len1 RUN", 32'(dbg_state), 1);
      @(negedge clk);
      chk("len1 DRAIN", 32'(dbg_state), 2);
      chk("len1 tlast", 32'(M_AXI_TLAST), 1);
      chk("len1 data", M_AXI_TDATA, 32'hCAFE_0001);
      @(negedge clk);
      chk("len1 IDLE", 32'(dbg_state), 0);
      chk("len1 done", 32'(pkt_done), 1);
      @(posedge clk); #1 S_AXI_TVALID = 1'b0;
      // reset mid-packet after 3 beats accepted
      cfg_len = 10'd8; start = 1'b1; S_AXI_TVALID = 1'b1; S_AXI_TDATA = 32'hDEAD_0000;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (dbg_in_cnt != 10'd3 && n < 20) begin @(posedge clk); #1; n++; end
      chk("mid in_cnt reached", 32'(dbg_in_cnt), 3);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid rst tvalid", 32'(M_AXI_TVALID), 0);
      chk("mid rst tlast", 32'(M_AXI_TLAST), 0);
      chk("mid rst tdata", M_AXI_TDATA, 0);
      chk("mid rst sready", 32'(S_AXI_TREADY), 0);
      chk("mid rst busy", 32'(busy), 0);
      chk("mid rst in_cnt", 32'(dbg_in_cnt), 0);
      @(posedge clk); #1;
      reset = 1'b0; S_AXI_TVALID = 1'b0;
      @(posedge clk); #1;
      v2 = '{2, 4'b1111, 1'b0, 2, 1, 0};
      run_pkt(v2, 32'h5A5A_0000);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
